// File: rtl/chg_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding,
// denomination values and coin_sel codes, plus a code-to-value lookup.
package chg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PICK,
        ST_ISSUE,
        ST_FINISH
    } state_t;

    localparam int unsigned NUM_DENOM = 5;

    localparam logic [9:0] VAL_RM1 = 10'd100;
    localparam logic [9:0] VAL_50  = 10'd50;
    localparam logic [9:0] VAL_20  = 10'd20;
    localparam logic [9:0] VAL_10  = 10'd10;
    localparam logic [9:0] VAL_5   = 10'd5;

    localparam logic [2:0] SEL_RM1 = 3'd0;
    localparam logic [2:0] SEL_50  = 3'd1;
    localparam logic [2:0] SEL_20  = 3'd2;
    localparam logic [2:0] SEL_10  = 3'd3;
    localparam logic [2:0] SEL_5   = 3'd4;

    function automatic logic [9:0] denom_value(input logic [2:0] sel);
        logic [9:0] v;
        case (sel)
            SEL_RM1: v = VAL_RM1;
            SEL_50:  v = VAL_50;
            SEL_20:  v = VAL_20;
            SEL_10:  v = VAL_10;
            SEL_5:   v = VAL_5;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/chg_coin_pick.sv
// Combinational selector: largest usable denomination not exceeding the
// remaining amount. Codes are ordered largest value first, so the lowest
// usable code that fits wins.
module chg_coin_pick
    import chg_pkg::*;
(
    input  logic [9:0] remaining_i,
    input  logic [4:0] usable_i,
    output logic       found_o,
    output logic [2:0] sel_o,
    output logic [9:0] val_o
);

    // Priority scan from the largest denomination downwards.
    always_comb begin
        logic hit;
        hit     = 1'b0;
        found_o = 1'b0;
        sel_o   = '0;
        val_o   = '0;
        for (int unsigned i = 0; i < NUM_DENOM; i++) begin
            if (!hit && usable_i[i] && (denom_value(3'(i)) <= remaining_i)) begin
                hit     = 1'b1;
                found_o = 1'b1;
                sel_o   = 3'(i);
                val_o   = denom_value(3'(i));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin payout controller: converts a change amount into one-coin-at-a-time
// hopper requests, largest denomination first, skipping empty or timed-out
// hoppers and reporting any residue.
// Build option: define CHG_5SEN_EN to include the 5-sen hopper (code 4).
module change_dispenser
    import chg_pkg::*;
#(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] change,
    input  logic       refund,
    input  logic       refundall,
    input  logic [4:0] hopper_empty,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [2:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [9:0] residue
);

`ifdef CHG_5SEN_EN
    localparam logic [4:0] DENOM_EN = 5'b11111;
`else
    localparam logic [4:0] DENOM_EN = 5'b01111;
`endif

    state_t          state_q, state_d;
    logic [9:0]      remaining_q, remaining_d;
    logic [4:0]      failed_q, failed_d;
    logic [2:0]      sel_q, sel_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            fault_q, fault_d;
    logic [9:0]      residue_q, residue_d;

    logic       load;
    logic [4:0] usable;
    logic       pick_found;
    logic [2:0] pick_sel;
    logic [9:0] pick_val;

    assign load   = refund | refundall;
    assign usable = DENOM_EN & ~hopper_empty & ~failed_q;

    chg_coin_pick u_pick (
        .remaining_i (remaining_q),
        .usable_i    (usable),
        .found_o     (pick_found),
        .sel_o       (pick_sel),
        .val_o       (pick_val)
    );

    assign coin_sel = sel_q;
    assign fault    = fault_q;
    assign residue  = residue_q;

    // State and datapath registers; async reset abandons any payout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            failed_q    <= '0;
            sel_q       <= '0;
            to_cnt_q    <= '0;
            fault_q     <= 1'b0;
            residue_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            failed_q    <= failed_d;
            sel_q       <= sel_d;
            to_cnt_q    <= to_cnt_d;
            fault_q     <= fault_d;
            residue_q   <= residue_d;
        end
    end

    // Next-state logic and state-decoded outputs (req/busy/done drop with state on reset).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        failed_d    = failed_q;
        sel_d       = sel_q;
        to_cnt_d    = to_cnt_q;
        fault_d     = fault_q;
        residue_d   = residue_q;
        coin_req    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    if (change != '0) begin
                        remaining_d = change;
                        failed_d    = '0;
                        fault_d     = 1'b0;
                        residue_d   = '0;
                        state_d     = ST_PICK;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            ST_PICK: begin
                busy = 1'b1;
                if (remaining_q == '0) begin
                    residue_d = '0;
                    state_d   = ST_FINISH;
                end else if (pick_found) begin
                    sel_d    = pick_sel;
                    to_cnt_d = '0;
                    state_d  = ST_ISSUE;
                end else begin
                    residue_d = remaining_q;
                    fault_d   = 1'b1;
                    state_d   = ST_FINISH;
                end
            end
            ST_ISSUE: begin
                busy     = 1'b1;
                coin_req = 1'b1;
                if (coin_ack) begin
                    remaining_d = remaining_q - denom_value(sel_q);
                    state_d     = ST_PICK;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    // Request has been held for TIMEOUT cycles without an ack.
                    failed_d[sel_q] = 1'b1;
                    state_d         = ST_PICK;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pick_val mirrors denom_value(pick_sel); kept on the picker interface.
    logic unused_pick_val;
    assign unused_pick_val = ^pick_val;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

    localparam int unsigned TO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] change;
    logic       refund;
    logic       refundall;
    logic [4:0] hopper_empty;
    logic       coin_ack;
    logic       coin_req;
    logic [2:0] coin_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [9:0] residue;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;
    int unsigned done_cnt = 0;

    change_dispenser #(.TIMEOUT(TO), .TO_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .change       (change),
        .refund       (refund),
        .refundall    (refundall),
        .hopper_empty (hopper_empty),
        .coin_ack     (coin_ack),
        .coin_req     (coin_req),
        .coin_sel     (coin_sel),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .residue      (residue)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] amt, input bit all);
        @(negedge clk);
        change    = amt;
        refund    = !all;
        refundall = all;
        @(negedge clk);
        refund    = 1'b0;
        refundall = 1'b0;
    endtask

    task automatic wait_req();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (coin_req) seen = 1;
            else @(negedge clk);
        end
    endtask

    task automatic get_coin(input string tag, input logic [2:0] exp_sel);
        wait_req();
        check({tag, " req"}, 32'(coin_req), 32'd1);
        check({tag, " sel"}, 32'(coin_sel), 32'(exp_sel));
        coin_ack = 1'b1;
        @(negedge clk);
        check({tag, " req_drop"}, 32'(coin_req), 32'd0);
        coin_ack = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [9:0] exp_res, input logic exp_fault);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_fin"}, 32'(busy), 32'd0);
        check({tag, " residue"}, 32'(residue), 32'(exp_res));
        check({tag, " fault"}, 32'(fault), 32'(exp_fault));
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " residue_hold"}, 32'(residue), 32'(exp_res));
        check({tag, " fault_hold"}, 32'(fault), 32'(exp_fault));
    endtask

    initial begin
        int unsigned d0;
        int unsigned n;

        rst          = 1'b1;
        change       = '0;
        refund       = 1'b0;
        refundall    = 1'b0;
        hopper_empty = '0;
        coin_ack     = 1'b0;
        #2;
        check("rst coin_req", 32'(coin_req), 32'd0);
        check("rst coin_sel", 32'(coin_sel), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        check("rst residue", 32'(residue), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Zero-amount request: immediate done, no payout
        @(negedge clk);
        change = '0;
        refund = 1'b1;
        #1;
        check("zero done", 32'(done), 32'd1);
        check("zero busy", 32'(busy), 32'd0);
        @(negedge clk);
        refund = 1'b0;
        check("zero idle", 32'(busy), 32'd0);

        // 280 with all hoppers full
        d0 = done_cnt;
        load(10'd280, 1'b0);
        check("t280 busy", 32'(busy), 32'd1);
        get_coin("t280 c1", 3'd0);
        get_coin("t280 c2", 3'd0);
        get_coin("t280 c3", 3'd1);
        get_coin("t280 c4", 3'd2);
        get_coin("t280 c5", 3'd3);
        wait_done("t280", 10'd0, 1'b0);
        check("t280 done_count", done_cnt - d0, 32'd1);

        // 101 via refundall: one RM1, residue 1
        load(10'd101, 1'b1);
        get_coin("t101 c1", 3'd0);
        wait_done("t101", 10'd1, 1'b1);

        // RM1 hopper empty, 200: four 50-sen coins; fault cleared on load
        hopper_empty = 5'b00001;
        load(10'd200, 1'b0);
        check("t200 fault_clr", 32'(fault), 32'd0);
        check("t200 residue_clr", 32'(residue), 32'd0);
        get_coin("t200 c1", 3'd1);
        get_coin("t200 c2", 3'd1);
        get_coin("t200 c3", 3'd1);
        get_coin("t200 c4", 3'd1);
        wait_done("t200", 10'd0, 1'b0);
        hopper_empty = '0;

        // 30 with 20-sen hopper silent: timeout then three 10-sen coins
        load(10'd30, 1'b0);
        wait_req();
        check("t30 sel20", 32'(coin_sel), 32'd2);
        n = 0;
        while (coin_req && n < TO + 10) begin
            n++;
            @(negedge clk);
        end
        check("t30 timeout_len", n, TO);
        get_coin("t30 c1", 3'd3);
        get_coin("t30 c2", 3'd3);
        get_coin("t30 c3", 3'd3);
        wait_done("t30", 10'd0, 1'b0);

        // 15: 10-sen coin then 5-sen only if enabled
        load(10'd15, 1'b0);
        get_coin("t15 c1", 3'd3);
`ifdef CHG_5SEN_EN
        get_coin("t15 c2", 3'd4);
        wait_done("t15", 10'd0, 1'b0);
`else
        wait_done("t15", 10'd5, 1'b1);
`endif

        // Reset during ISSUE drops outputs without a clock edge
        load(10'd50, 1'b0);
        wait_req();
        check("trst sel", 32'(coin_sel), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("trst coin_req", 32'(coin_req), 32'd0);
        check("trst busy", 32'(busy), 32'd0);
        check("trst done", 32'(done), 32'd0);
        check("trst residue", 32'(residue), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load(10'd10, 1'b0);
        get_coin("t10 c1", 3'd3);
        wait_done("t10", 10'd0, 1'b0);

        // Load while busy is ignored
        d0 = done_cnt;
        load(10'd60, 1'b0);
        get_coin("tign c1", 3'd1);
        change = 10'd100;
        refund = 1'b1;
        @(negedge clk);
        refund = 1'b0;
        get_coin("tign c2", 3'd3);
        wait_done("tign", 10'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("tign idle_busy", 32'(busy), 32'd0);
        check("tign idle_req", 32'(coin_req), 32'd0);
        check("tign done_count", done_cnt - d0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
